vec_exec_pipe: RTL

- Parametrised, multi-stage SIMD execution pipeline for the next-generation cardinal core. It replaces the single-cycle EX/MEM ALU path.
- Operands arrive from the ID stage through a valid/ready handshake, are processed at selectable subword width (ww) and leave after STAGES cycles with writeback metadata (rd, ppp, wr_en).
- Adds three things the current core lacks:
  - back-pressure stall
  - branch flush
  - saturating arithmetic with per-op overflow flagging
- A register scoreboard query lets the ID-stage hazard unit stall on in-flight writers.

---
 rtl/vec_exec_pipe.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vec_exec_pipe.sv
// Multi-stage SIMD execution pipeline: lane ALU in stage 1, delay stages after,
// global valid/ready stall, branch flush and a combinational in-flight writer scoreboard.
module vec_exec_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 3,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_func,
  input  logic [1:0]        in_ww,
  input  logic [2:0]        in_ppp,
  input  logic [RF_AW-1:0]  in_rd,
  input  logic              in_wr_en,
  input  logic              in_sat,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RF_AW-1:0]  out_rd,
  output logic [2:0]        out_ppp,
  output logic              out_wr_en,
  output logic              out_ovf,
  output logic              out_illegal,
  input  logic [RF_AW-1:0]  q_addr0,
  input  logic [RF_AW-1:0]  q_addr1,
  output logic              q_busy0,
  output logic              q_busy1
);

  typedef enum logic [5:0] {
    F_VAND = 6'h01, F_VOR, F_VXOR, F_VNOT, F_VMOV, F_VADD, F_VSUB, F_VSLL, F_VSRL
  } func_e;

  localparam int unsigned N8  = DATA_W / 8;
  localparam int unsigned N16 = DATA_W / 16;
  localparam int unsigned N32 = DATA_W / 32;
  localparam int unsigned N64 = DATA_W / 64;

  // One lane, operands zero-extended to 64 bits; returns {overflow, result}.
  function automatic logic [64:0] lane_op(input logic [5:0] func, input logic sat,
                                          input logic [1:0] ww, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] mask, r;
    logic [64:0] sum;
    logic [5:0]  shm;
    logic        ovf;
    unique case (ww)
      2'b00:   begin mask = 64'hFF;        shm = 6'd7;  end
      2'b01:   begin mask = 64'hFFFF;      shm = 6'd15; end
      2'b10:   begin mask = 64'hFFFF_FFFF; shm = 6'd31; end
      default: begin mask = '1;            shm = 6'd63; end
    endcase
    sum = {1'b0, a} + {1'b0, b};
    ovf = 1'b0;
    r   = '0;
    case (func)
      F_VAND: r = a & b;
      F_VOR:  r = a | b;
      F_VXOR: r = a ^ b;
      F_VNOT: r = ~a;
      F_VMOV: r = a;
      F_VADD: begin
        // carry out of a narrow lane lands just above the lane mask
        ovf = sum[64] | (|(sum[63:0] & ~mask));
        r   = (ovf && sat) ? mask : sum[63:0];
      end
      F_VSUB: begin
        ovf = (a < b);
        r   = (ovf && sat) ? '0 : a - b;
      end
      F_VSLL: r = a << (b[5:0] & shm);
      F_VSRL: r = a >> (b[5:0] & shm);
      default: r = '0;
    endcase
    return {ovf, r & mask};
  endfunction

  logic              advance, legal, c_ovf;
  logic [DATA_W-1:0] c_data;
  logic [64:0]       lr;

  logic              st_v    [STAGES];
  logic [DATA_W-1:0] st_data [STAGES];
  logic [RF_AW-1:0]  st_rd   [STAGES];
  logic [2:0]        st_ppp  [STAGES];
  logic              st_we   [STAGES];
  logic              st_ovf  [STAGES];
  logic              st_ill  [STAGES];

  assign advance  = !st_v[STAGES-1] || out_ready;
  assign in_ready = advance && !flush && reset;
  assign legal    = (in_func >= F_VAND) && (in_func <= F_VSRL);

  // Lane 0 occupies the most significant bits of the operand vectors.
  always_comb begin
    c_data = '0;
    c_ovf  = 1'b0;
    lr     = '0;
    unique case (in_ww)
      2'b00: for (int unsigned i = 0; i < N8; i++) begin
        lr = lane_op(in_func, in_sat, in_ww, 64'(in_a[DATA_W-1-i*8 -: 8]), 64'(in_b[DATA_W-1-i*8 -: 8]));
        c_data[DATA_W-1-i*8 -: 8] = lr[7:0];
        c_ovf = c_ovf | lr[64];
      end
      2'b01: for (int unsigned i = 0; i < N16; i++) begin
        lr = lane_op(in_func, in_sat, in_ww, 64'(in_a[DATA_W-1-i*16 -: 16]), 64'(in_b[DATA_W-1-i*16 -: 16]));
        c_data[DATA_W-1-i*16 -: 16] = lr[15:0];
        c_ovf = c_ovf | lr[64];
      end
      2'b10: for (int unsigned i = 0; i < N32; i++) begin
        lr = lane_op(in_func, in_sat, in_ww, 64'(in_a[DATA_W-1-i*32 -: 32]), 64'(in_b[DATA_W-1-i*32 -: 32]));
        c_data[DATA_W-1-i*32 -: 32] = lr[31:0];
        c_ovf = c_ovf | lr[64];
      end
      default: for (int unsigned i = 0; i < N64; i++) begin
        lr = lane_op(in_func, in_sat, in_ww, in_a[DATA_W-1-i*64 -: 64], in_b[DATA_W-1-i*64 -: 64]);
        c_data[DATA_W-1-i*64 -: 64] = lr[63:0];
        c_ovf = c_ovf | lr[64];
      end
    endcase
    if (!legal) begin
      c_data = '0;
      c_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_v[k]    <= 1'b0;
        st_data[k] <= '0;
        st_rd[k]   <= '0;
        st_ppp[k]  <= '0;
        st_we[k]   <= 1'b0;
        st_ovf[k]  <= 1'b0;
        st_ill[k]  <= 1'b0;
      end
    end else if (flush) begin
      for (int unsigned k = 0; k < STAGES; k++) st_v[k] <= 1'b0;
    end else if (advance) begin
      st_v[0]    <= in_valid;
      st_data[0] <= c_data;
      st_rd[0]   <= in_rd;
      st_ppp[0]  <= in_ppp;
      st_we[0]   <= in_wr_en && legal;
      st_ovf[0]  <= c_ovf;
      st_ill[0]  <= !legal;
      for (int unsigned k = 1; k < STAGES; k++) begin
        st_v[k]    <= st_v[k-1];
        st_data[k] <= st_data[k-1];
        st_rd[k]   <= st_rd[k-1];
        st_ppp[k]  <= st_ppp[k-1];
        st_we[k]   <= st_we[k-1];
        st_ovf[k]  <= st_ovf[k-1];
        st_ill[k]  <= st_ill[k-1];
      end
    end
  end

  always_comb begin
    q_busy0 = 1'b0;
    q_busy1 = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (st_v[k] && st_we[k] && (st_rd[k] == q_addr0)) q_busy0 = 1'b1;
      if (st_v[k] && st_we[k] && (st_rd[k] == q_addr1)) q_busy1 = 1'b1;
    end
    q_busy0 = q_busy0 && (q_addr0 != '0);
    q_busy1 = q_busy1 && (q_addr1 != '0);
  end

  assign out_valid   = st_v[STAGES-1];
  assign out_data    = st_data[STAGES-1];
  assign out_rd      = st_rd[STAGES-1];
  assign out_ppp     = st_ppp[STAGES-1];
  assign out_wr_en   = st_we[STAGES-1];
  assign out_ovf     = st_ovf[STAGES-1];
  assign out_illegal = st_ill[STAGES-1];

endmodule
